// File: rtl/muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// Module  : muldiv_unit_if
// Brief   : Request, flush and pending-writeback bundle of the M-extension unit.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface muldiv_unit_if #(
    parameter int XLEN       = 32,
    parameter int HART_ID_W  = 2,
    parameter int REG_ADDR_W = 5
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_op;
    logic [XLEN-1:0]       req_a;
    logic [XLEN-1:0]       req_b;
    logic [HART_ID_W-1:0]  req_hart_id;
    logic [REG_ADDR_W-1:0] req_rd;
    logic                  flush;
    logic [HART_ID_W-1:0]  flush_hart_id;
    logic                  busy;
    logic [HART_ID_W-1:0]  busy_hart_id;
    logic                  muldiv_pending;
    logic [HART_ID_W-1:0]  muldiv_pending_hart_id;
    logic [REG_ADDR_W-1:0] muldiv_pending_rd;
    logic [XLEN-1:0]       muldiv_pending_result;
    logic                  muldiv_wb_fire;

    // Pipeline side: issues ops, flushes harts, consumes the writeback.
    modport master (
        output req_valid, req_op, req_a, req_b, req_hart_id, req_rd,
        output flush, flush_hart_id, muldiv_wb_fire,
        input  req_ready, busy, busy_hart_id,
        input  muldiv_pending, muldiv_pending_hart_id, muldiv_pending_rd,
        input  muldiv_pending_result
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_hart_id, req_rd,
        input  flush, flush_hart_id, muldiv_wb_fire,
        output req_ready, busy, busy_hart_id,
        output muldiv_pending, muldiv_pending_hart_id, muldiv_pending_rd,
        output muldiv_pending_result
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// Module  : muldiv_unit
// Brief   : Iterative RV32M multiply/divide, one bit per cycle, with a
//           pending-writeback hold until the arbiter fires it.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int HART_ID_W  = 2,
    parameter int REG_ADDR_W = 5
) (
    input  wire logic     clk,
    input  wire logic     rst,
    muldiv_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_OP_MUL    = 3'b000;
    localparam logic [2:0] c_OP_MULH   = 3'b001;
    localparam logic [2:0] c_OP_MULHSU = 3'b010;
    localparam logic [2:0] c_OP_MULHU  = 3'b011;
    localparam logic [2:0] c_OP_DIV    = 3'b100;
    localparam logic [2:0] c_OP_DIVU   = 3'b101;
    localparam logic [2:0] c_OP_REM    = 3'b110;
    localparam logic [2:0] c_OP_REMU   = 3'b111;
    localparam logic [4:0] c_LAST_ITER = 5'd31;
    localparam logic [XLEN-1:0] c_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_op;
    logic [HART_ID_W-1:0]  r_hart_id;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [XLEN-1:0]       r_result;
    logic [4:0]            r_count;
    logic                  r_neg_res;
    logic                  r_neg_rem;
    logic [XLEN-1:0]       r_b_mag;
    logic [XLEN-1:0]       r_hi;
    logic [XLEN-1:0]       r_lo;

    // Request decode
    logic            w_accept;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_by_zero;
    logic            w_overflow;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_result;

    assign w_accept   = bus.req_valid && (r_state == S_IDLE);
    assign w_a_signed = (bus.req_op != c_OP_MULHU) && (bus.req_op != c_OP_DIVU) &&
                        (bus.req_op != c_OP_REMU);
    assign w_b_signed = (bus.req_op == c_OP_MUL) || (bus.req_op == c_OP_MULH) ||
                        (bus.req_op == c_OP_DIV) || (bus.req_op == c_OP_REM);
    assign w_a_neg    = w_a_signed && bus.req_a[XLEN-1];
    assign w_b_neg    = w_b_signed && bus.req_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? (~bus.req_a + 1'b1) : bus.req_a;
    assign w_b_mag    = w_b_neg ? (~bus.req_b + 1'b1) : bus.req_b;

    assign w_div_by_zero = bus.req_op[2] && (bus.req_b == '0);
    assign w_overflow    = ((bus.req_op == c_OP_DIV) || (bus.req_op == c_OP_REM)) &&
                           (bus.req_a == c_INT_MIN) && (bus.req_b == '1);
    assign w_fast        = w_div_by_zero || w_overflow;

    // op[1] distinguishes REM/REMU from DIV/DIVU on the fast path
    always_comb begin
        w_fast_result = '0;
        if (w_div_by_zero) begin
            w_fast_result = bus.req_op[1] ? bus.req_a : '1;
        end else if (w_overflow) begin
            w_fast_result = bus.req_op[1] ? '0 : c_INT_MIN;
        end
    end

    // One iteration: multiply shifts {hi,lo} right, divide shifts it left.
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_shift;
    logic [XLEN:0]   w_div_diff;
    logic            w_div_ok;
    logic [XLEN-1:0] w_hi_nxt;
    logic [XLEN-1:0] w_lo_nxt;

    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b_mag} : '0);
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b_mag};
    assign w_div_ok    = !w_div_diff[XLEN];

    always_comb begin
        w_hi_nxt = w_mul_sum[XLEN:1];
        w_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};
        if (r_op[2]) begin
            w_hi_nxt = w_div_ok ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], w_div_ok};
        end
    end

    // Sign fix-up and result selection for the final iteration
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_calc_result;

    assign w_prod     = {w_hi_nxt, w_lo_nxt};
    assign w_prod_fix = r_neg_res ? (~w_prod + 1'b1) : w_prod;
    assign w_quot_fix = r_neg_res ? (~w_lo_nxt + 1'b1) : w_lo_nxt;
    assign w_rem_fix  = r_neg_rem ? (~w_hi_nxt + 1'b1) : w_hi_nxt;

    always_comb begin
        w_calc_result = '0;
        case (r_op)
            c_OP_MUL:                           w_calc_result = w_prod_fix[XLEN-1:0];
            c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_calc_result = w_prod_fix[2*XLEN-1:XLEN];
            c_OP_DIV, c_OP_DIVU:                w_calc_result = w_quot_fix;
            c_OP_REM, c_OP_REMU:                w_calc_result = w_rem_fix;
            default:                            w_calc_result = '0;
        endcase
    end

    logic w_flush_hit;
    assign w_flush_hit = bus.flush && (bus.flush_hart_id == r_hart_id);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_fast ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_flush_hit) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.muldiv_wb_fire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_hart_id <= '0;
            r_rd      <= '0;
            r_result  <= '0;
            r_count   <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b_mag   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= bus.req_op;
                        r_hart_id <= bus.req_hart_id;
                        r_rd      <= bus.req_rd;
                        r_count   <= c_LAST_ITER;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_b_mag   <= w_b_mag;
                        r_hi      <= '0;
                        r_lo      <= w_a_mag;
                        if (w_fast) begin
                            r_result <= w_fast_result;
                        end
                    end
                end
                S_CALC: begin
                    if (!w_flush_hit) begin
                        r_hi    <= w_hi_nxt;
                        r_lo    <= w_lo_nxt;
                        r_count <= r_count - 5'd1;
                        if (r_count == '0) begin
                            r_result <= w_calc_result;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready              = (r_state == S_IDLE);
    assign bus.busy                   = (r_state != S_IDLE);
    assign bus.busy_hart_id           = (r_state != S_IDLE) ? r_hart_id : '0;
    assign bus.muldiv_pending         = (r_state == S_DONE);
    assign bus.muldiv_pending_hart_id = r_hart_id;
    assign bus.muldiv_pending_rd      = r_rd;
    assign bus.muldiv_pending_result  = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// Module  : tb_muldiv_unit
// Brief   : Self-checking bench for muldiv_unit: vector table, flush/reset/hold
//           sequences and random ops against an arithmetic reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32), .HART_ID_W(2), .REG_ADDR_W(5)) bus ();

    muldiv_unit #(.XLEN(32), .HART_ID_W(2), .REG_ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  hart;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
        int          flush_cycle;
        logic [1:0]  flush_hart;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on sign/zero-extended operands
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op with wb_fire held high; optionally pulse flush in a given cycle
    task automatic do_vec(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] hart, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat,
                          input int flush_cycle, input logic [1:0] flush_hart);
        int lat;
        @(negedge clk);
        bus.req_valid      = 1'b1;
        bus.req_op         = op;
        bus.req_a          = a;
        bus.req_b          = b;
        bus.req_hart_id    = hart;
        bus.req_rd         = rd;
        bus.muldiv_wb_fire = 1'b1;
        bus.flush          = (flush_cycle == 0);
        bus.flush_hart_id  = flush_hart;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        lat = 1;
        if (exp_lat > 1) check({name, "/busy_hart"}, {bus.busy, bus.busy_hart_id}, {1'b1, hart});
        while (!bus.muldiv_pending && lat < 40) begin
            bus.flush = (lat == flush_cycle);
            @(posedge clk); #1;
            lat++;
        end
        bus.flush = 1'b0;
        check({name, "/latency"}, lat, exp_lat);
        check({name, "/result"}, bus.muldiv_pending_result, exp_res);
        check({name, "/hart"}, bus.muldiv_pending_hart_id, hart);
        check({name, "/rd"}, bus.muldiv_pending_rd, rd);
        @(posedge clk); #1;
        check({name, "/idle_after"}, {bus.req_ready, bus.muldiv_pending}, 2'b10);
        bus.muldiv_wb_fire = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] hart, input logic [4:0] rd);
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_op      = op;
        bus.req_a       = a;
        bus.req_b       = b;
        bus.req_hart_id = hart;
        bus.req_rd      = rd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic expect_no_pending(input string name);
        int seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.muldiv_pending) seen++;
        end
        check(name, seen, 0);
    endtask

    initial begin
        logic [31:0] a, b, r;
        logic [2:0]  op;
        logic [1:0]  h;
        logic [4:0]  rd;
        int          waited;

        rst                = 1'b1;
        bus.req_valid      = 1'b0;
        bus.req_op         = '0;
        bus.req_a          = '0;
        bus.req_b          = '0;
        bus.req_hart_id    = '0;
        bus.req_rd         = '0;
        bus.flush          = 1'b0;
        bus.flush_hart_id  = '0;
        bus.muldiv_wb_fire = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/ctrl", {bus.req_ready, bus.busy, bus.muldiv_pending}, 3'b100);
        check("reset/regs", {bus.busy_hart_id, bus.muldiv_pending_hart_id, bus.muldiv_pending_rd,
                             bus.muldiv_pending_result}, 0);
        rst = 1'b0;

        vecs.push_back('{"mul",        3'd0, 32'd7,        32'hFFFFFFFD, 2'd1, 5'd5,  32'hFFFFFFEB, 33, -1, 2'd0});
        vecs.push_back('{"mulh",       3'd1, 32'h80000000, 32'h80000000, 2'd0, 5'd1,  32'h40000000, 33, -1, 2'd0});
        vecs.push_back('{"mulhu",      3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd2, 5'd0,  32'hFFFFFFFE, 33, -1, 2'd0});
        vecs.push_back('{"mulhsu",     3'd2, 32'hFFFFFFFF, 32'd2,        2'd3, 5'd9,  32'hFFFFFFFF, 33, -1, 2'd0});
        vecs.push_back('{"div_neg",    3'd4, 32'hFFFFFFF9, 32'd2,        2'd1, 5'd10, 32'hFFFFFFFD, 33, -1, 2'd0});
        vecs.push_back('{"rem_neg",    3'd6, 32'hFFFFFFF9, 32'd2,        2'd1, 5'd11, 32'hFFFFFFFF, 33, -1, 2'd0});
        vecs.push_back('{"divu",       3'd5, 32'd100,      32'd7,        2'd2, 5'd12, 32'd14,       33, -1, 2'd0});
        vecs.push_back('{"remu",       3'd7, 32'd100,      32'd7,        2'd2, 5'd13, 32'd2,        33, -1, 2'd0});
        vecs.push_back('{"div_by0",    3'd4, 32'd5,        32'd0,        2'd0, 5'd14, 32'hFFFFFFFF, 1,  -1, 2'd0});
        vecs.push_back('{"remu_by0",   3'd7, 32'd5,        32'd0,        2'd3, 5'd15, 32'd5,        1,  -1, 2'd0});
        vecs.push_back('{"divu_by0",   3'd5, 32'd5,        32'd0,        2'd1, 5'd16, 32'hFFFFFFFF, 1,  -1, 2'd0});
        vecs.push_back('{"rem_by0",    3'd6, 32'hFFFFFFF9, 32'd0,        2'd1, 5'd17, 32'hFFFFFFF9, 1,  -1, 2'd0});
        vecs.push_back('{"div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 2'd2, 5'd18, 32'h80000000, 1,  -1, 2'd0});
        vecs.push_back('{"rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 2'd2, 5'd19, 32'd0,        1,  -1, 2'd0});
        vecs.push_back('{"flush_oth",  3'd0, 32'd3,        32'd5,        2'd1, 5'd20, 32'd15,       33, 15, 2'd3});
        vecs.push_back('{"flush_acc",  3'd4, 32'd20,       32'hFFFFFFFD, 2'd0, 5'd21, 32'hFFFFFFFA, 33, 0,  2'd0});
        vecs.push_back('{"rem_divneg", 3'd6, 32'd20,       32'hFFFFFFFD, 2'd3, 5'd22, 32'd2,        33, -1, 2'd0});

        foreach (vecs[i])
            do_vec(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hart, vecs[i].rd,
                   vecs[i].exp, vecs[i].lat, vecs[i].flush_cycle, vecs[i].flush_hart);

        // Reset in the middle of a multiply
        issue(3'd0, 32'd12345, 32'd678, 2'd1, 5'd3);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid/ctrl", {bus.req_ready, bus.busy, bus.muldiv_pending}, 3'b100);
        expect_no_pending("rst_mid/no_pending");

        // Matching-hart flush in cycle 15 of CALC
        issue(3'd1, 32'hDEADBEEF, 32'h12345678, 2'd2, 5'd7);
        repeat (14) begin @(posedge clk); #1; end
        check("flush_hit/busy_before", {bus.busy, bus.busy_hart_id}, 3'b110);
        bus.flush         = 1'b1;
        bus.flush_hart_id = 2'd2;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_hit/idle", {bus.req_ready, bus.busy, bus.busy_hart_id}, 4'b1000);
        expect_no_pending("flush_hit/no_pending");

        // Hold in DONE without fire; a flush of the owning hart must not disturb it
        issue(3'd5, 32'd100, 32'd7, 2'd3, 5'd27);
        waited = 1;
        while (!bus.muldiv_pending && waited < 40) begin @(posedge clk); #1; waited++; end
        check("hold/latency", waited, 33);
        for (int i = 0; i < 6; i++) begin
            bus.flush         = (i == 2);
            bus.flush_hart_id = 2'd3;
            @(posedge clk); #1;
            check("hold/stable", {bus.muldiv_pending, bus.req_ready, bus.busy_hart_id,
                                  bus.muldiv_pending_hart_id, bus.muldiv_pending_rd,
                                  bus.muldiv_pending_result},
                  {1'b1, 1'b0, 2'd3, 2'd3, 5'd27, 32'd14});
        end
        bus.flush          = 1'b0;
        bus.muldiv_wb_fire = 1'b1;
        @(posedge clk); #1;
        bus.muldiv_wb_fire = 1'b0;
        check("hold/release", {bus.req_ready, bus.muldiv_pending, bus.busy}, 3'b100);

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            h  = 2'($urandom_range(0, 3));
            rd = 5'($urandom_range(0, 31));
            r  = ref_result(op, a, b);
            do_vec($sformatf("rand%0d_op%0d", i, op), op, a, b, h, rd, r,
                   ref_latency(op, a, b), -1, 2'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit for the multi-hart core.
- Accepts one M-extension op from EX, computes it over multiple cycles, then presents the result as a pending writeback.
- Holds the pending writeback until the writeback arbiter acknowledges it with muldiv_wb_fire.
- It is the producer end of the muldiv_pending / muldiv_wb_fire handshake.

Parameters:
- XLEN, 32, operand/result width; the datapath is fixed at 32 iterations.
- HART_ID_W, 2, hart id width.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  EX issues an M op this cycle
- req_ready  output  1  unit can accept an op (state IDLE)
- req_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_a  input  XLEN  rs1 value
- req_b  input  XLEN  rs2 value
- req_hart_id  input  HART_ID_W  issuing hart
- req_rd  input  REG_ADDR_W  destination register
- flush  input  1  pipeline flush request
- flush_hart_id  input  HART_ID_W  hart being flushed
- busy  output  1  state != IDLE
- busy_hart_id  output  HART_ID_W  hart owning the in-flight op (for EX hazard stalls)
- muldiv_pending  output  1  result waiting for writeback
- muldiv_pending_hart_id  output  HART_ID_W  owner hart
- muldiv_pending_rd  output  REG_ADDR_W  destination register
- muldiv_pending_result  output  XLEN  result
- muldiv_wb_fire  input  1  writeback arbiter consumed the pending result

Behaviour:
- Reset: state IDLE; req_ready=1; busy=0; muldiv_pending=0; hart_id/rd/result/counter registers cleared to 0. Reset wins over every other input in any state.
- States: IDLE, CALC, DONE.
- Accept: fires when req_valid && req_ready at a clock edge. The unit latches op, operands, hart_id and rd.
- req_ready is 1 only in IDLE. There is no accept in the cycle that leaves DONE.
- IDLE -> CALC on a normal accept. Counter is loaded with 31.
- Each CALC cycle performs one iteration.
  - Multiply: radix-2 shift-add on unsigned magnitudes into a 64-bit product.
  - Divide: restoring, on unsigned magnitudes.
- Iteration with counter==0: transition to DONE, apply sign fix-up, select the result.
- Latency: accept at edge of cycle 0 -> CALC cycles 1..32 -> muldiv_pending=1 from cycle 33.
- Fast path (IDLE -> DONE directly, pending in cycle 1):
  - Divide-by-zero, req_b==0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = req_a.
  - Signed overflow, DIV/REM with req_a=0x80000000 and req_b=0xFFFFFFFF: DIV result 0x80000000; REM result 0.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Sign fix-up:
  - Product is negated if operand signs differ.
  - Quotient is negated if operand signs differ.
  - Remainder takes the dividend's sign.
- Result selection: MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- DONE:
  - muldiv_pending=1. hart_id/rd/result are stable until fire.
  - muldiv_wb_fire=1 -> IDLE next cycle; pending drops.
  - muldiv_wb_fire=0 -> remain in DONE indefinitely.
  - rd==0 results still pass through DONE; the arbiter fires them immediately.
- muldiv_wb_fire while not in DONE is ignored.
- Flush:
  - flush && flush_hart_id==latched hart in CALC: abort to IDLE next cycle; no pending is produced.
  - Flush in DONE has no effect; the result belongs to a committed instruction.
  - Flush in IDLE coincident with accept: the op is accepted, because EX gates req_valid on flush.
  - Flush of a different hart: no effect.
- busy_hart_id equals the latched hart in CALC/DONE and 0 in IDLE.

Test Plan:
- Reset mid-CALC: accept MUL, assert rst at cycle 10 -> next cycle state IDLE, req_ready=1, busy=0, muldiv_pending=0; no pending ever appears.
- MUL 7 x 0xFFFFFFFD, hart 1, rd 5, wb_fire tied 1 -> pending exactly in cycle 33 with result 0xFFFFFFEB, hart 1, rd 5; IDLE in cycle 34.
- Multiply high halves:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- Divide:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - All appear in cycle 33.
- Fast path, each pending in cycle 1:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Hold and flush:
  - Pending with wb_fire=0 for 6 cycles -> outputs unchanged and req_ready=0; fire -> IDLE next cycle.
  - Flush matching hart at cycle 15 of CALC -> IDLE, no pending.
  - Flush of another hart -> result still in cycle 33.
